// File: rtl/ahb_lite_uart_dbg_master_pkg.sv
// Shared definitions for the UART debug bus master: AHB encodings,
// protocol byte codes and FSM state types.
package ahb_lite_uart_dbg_master_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA    = 4'b0011;

    localparam logic [7:0] CMD_WR  = 8'h57;  // 'W'
    localparam logic [7:0] CMD_RD  = 8'h52;  // 'R'
    localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR = 8'h45;  // 'E'
    localparam logic [7:0] RSP_UNK = 8'h3F;  // '?'
    localparam logic [7:0] RSP_TMO = 8'h54;  // 'T'

    typedef enum logic [2:0] {
        S_CMD, S_ADDR, S_DATA, S_AHB_A, S_AHB_D, S_RESP
    } state_e;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

endpackage

// File: rtl/ahb_lite_uart_dbg_master_if.sv
// AHB-Lite single-master bus bundle; master drives address/control/write data.
interface ahb_lite_uart_dbg_master_if;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic        HMASTLOCK;
    logic [3:0]  HPROT;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWRITE, HWDATA,
        input  HRDATA, HREADY, HRESP
    );
    modport slave (
        input  HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWRITE, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_lite_uart_dbg_master_phy.sv
// uart_dbg_phy: 8N1 receiver and transmitter, CLK_DIV clocks per bit.
// tx_ready also covers the last cycle of a stop bit so bytes go out back-to-back.
module uart_dbg_phy
    import ahb_lite_uart_dbg_master_pkg::*;
#(
    parameter int CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       srx,
    output logic       stx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_ready
);
    localparam int            CW        = $clog2(CLK_DIV);
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

    logic              srx_meta_q, srx_sync_q, srx_prev_q;
    rx_state_e         rx_state_q, rx_state_d;
    logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
    logic [2:0]        rx_bit_q, rx_bit_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_ferr_q, rx_ferr_d;
    tx_state_e         tx_state_q, tx_state_d;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
    logic [2:0]        tx_bit_q, tx_bit_d;
    logic [7:0]        tx_shift_q, tx_shift_d;
    logic              stx_q, stx_d;

    assign rx_data  = rx_shift_q;
    assign rx_valid = rx_valid_q;
    assign rx_ferr  = rx_ferr_q;
    assign stx      = stx_q;
    assign tx_busy  = (tx_state_q != TX_IDLE);
    assign tx_ready = (tx_state_q == TX_IDLE) ||
                      (tx_state_q == TX_STOP && tx_cnt_q == DIV_LAST);

    // Receiver: start edge, mid-start confirm, then one sample per bit centre.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves it unassigned (no latch).
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (srx_prev_q && !srx_sync_q) rx_state_d = RX_START;
            end
            RX_START: if (rx_cnt_q == HALF_LAST) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = srx_sync_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == DIV_LAST) begin
                rx_cnt_d   = '0;
                rx_shift_d = {srx_sync_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 1'b1;
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_cnt_q == DIV_LAST) begin
                rx_valid_d = srx_sync_q;
                rx_ferr_d  = !srx_sync_q;
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // Transmitter: start bit, 8 data bits LSB first, stop bit; restartable in the stop bit's last cycle.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        stx_d      = stx_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                stx_d    = 1'b1;
            end
            TX_START: if (tx_cnt_q == DIV_LAST) begin
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                stx_d      = tx_shift_q[0];
                tx_state_d = TX_DATA;
            end
            TX_DATA: if (tx_cnt_q == DIV_LAST) begin
                tx_cnt_d = '0;
                if (tx_bit_q == 3'd7) begin
                    stx_d      = 1'b1;
                    tx_state_d = TX_STOP;
                end else begin
                    tx_bit_d   = tx_bit_q + 1'b1;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    stx_d      = tx_shift_q[1];
                end
            end
            TX_STOP: if (tx_cnt_q == DIV_LAST) begin
                stx_d      = 1'b1;
                tx_state_d = TX_IDLE;
            end
        endcase
        if (tx_start && tx_ready) begin
            tx_state_d = TX_START;
            tx_cnt_d   = '0;
            tx_shift_d = tx_data;
            stx_d      = 1'b0;
        end
    end

    // State registers; the serial line idles high out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            srx_meta_q <= 1'b1;
            srx_sync_q <= 1'b1;
            srx_prev_q <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            stx_q      <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            srx_meta_q <= srx;
            srx_sync_q <= srx_meta_q;
            srx_prev_q <= srx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            stx_q      <= stx_d;
        end
    end

endmodule

// File: rtl/ahb_lite_uart_dbg_master.sv
// UART-driven AHB-Lite debug master: parses 'W'/'R' commands, issues one
// 32-bit single transfer, returns 'K' / read data / 'E' / '?' serially.
// Optional macro UART_DBG_MASTER_TIMEOUT_EN: abort after TIMEOUT_CYC
// consecutive HREADY-low cycles and answer 'T' (bus may be left mid-transfer).
module ahb_lite_uart_dbg_master
    import ahb_lite_uart_dbg_master_pkg::*;
#(
    parameter int CLK_DIV     = 434,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                              HCLK,
    input  logic                              HRESET,
    ahb_lite_uart_dbg_master_if.master        ahb,
    input  logic                              UART_SRX,
    output logic                              UART_STX,
    output logic                              DBG_BUSY
);
    if (CLK_DIV < 16 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("CLK_DIV must be >= 16 and TIMEOUT_CYC >= 1");
    end

    logic [7:0]  rx_data;
    logic        rx_valid, rx_ferr, tx_start, tx_busy, tx_ready;
    logic [31:0] fld_nxt;

    state_e      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] fld_q, fld_d;
    logic [31:0] rsp_q, rsp_d;
    logic [2:0]  rsp_cnt_q, rsp_cnt_d;
    logic [1:0]  htrans_q, htrans_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic        busy_q, busy_d;
`ifdef UART_DBG_MASTER_TIMEOUT_EN
    localparam int            TW       = ($clog2(TIMEOUT_CYC) < 1) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    uart_dbg_phy #(.CLK_DIV(CLK_DIV)) u_phy (
        .clk      (HCLK),
        .rst      (HRESET),
        .srx      (UART_SRX),
        .stx      (UART_STX),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr),
        .tx_data  (rsp_q[31:24]),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .tx_ready (tx_ready)
    );

    assign fld_nxt       = {fld_q[23:0], rx_data};
    assign ahb.HADDR     = haddr_q;
    assign ahb.HTRANS    = htrans_q;
    assign ahb.HWRITE    = hwrite_q;
    assign ahb.HWDATA    = hwdata_q;
    assign ahb.HBURST    = HBURST_SINGLE;
    assign ahb.HMASTLOCK = 1'b0;
    assign ahb.HPROT     = HPROT_DATA;
    assign ahb.HSIZE     = HSIZE_WORD;
    assign DBG_BUSY      = busy_q;

    // Command parser, bus master and response sequencer next-state logic.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        is_wr_d    = is_wr_q;
        fld_d      = fld_q;
        rsp_d      = rsp_q;
        rsp_cnt_d  = rsp_cnt_q;
        htrans_d   = htrans_q;
        haddr_d    = haddr_q;
        hwrite_d   = hwrite_q;
        hwdata_d   = hwdata_q;
        tx_start   = 1'b0;
        case (state_q)
            S_CMD: if (rx_valid) begin
                if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                    is_wr_d    = (rx_data == CMD_WR);
                    byte_cnt_d = '0;
                    state_d    = S_ADDR;
                end else begin
                    rsp_d     = {RSP_UNK, 24'h0};
                    rsp_cnt_d = 3'd1;
                    state_d   = S_RESP;
                end
            end
            S_ADDR: if (rx_ferr) begin
                state_d = S_CMD;
            end else if (rx_valid) begin
                fld_d      = fld_nxt;
                byte_cnt_d = byte_cnt_q + 1'b1;
                if (byte_cnt_q == 2'd3) begin
                    haddr_d = {fld_nxt[31:2], 2'b00};
                    if (is_wr_q) begin
                        state_d = S_DATA;
                    end else begin
                        hwrite_d = 1'b0;
                        htrans_d = HTRANS_NONSEQ;
                        state_d  = S_AHB_A;
                    end
                end
            end
            S_DATA: if (rx_ferr) begin
                state_d = S_CMD;
            end else if (rx_valid) begin
                fld_d      = fld_nxt;
                byte_cnt_d = byte_cnt_q + 1'b1;
                if (byte_cnt_q == 2'd3) begin
                    hwdata_d = fld_nxt;
                    hwrite_d = 1'b1;
                    htrans_d = HTRANS_NONSEQ;
                    state_d  = S_AHB_A;
                end
            end
            S_AHB_A: if (ahb.HREADY) begin
                htrans_d = HTRANS_IDLE;
                state_d  = S_AHB_D;
            end
            // HRESP with HREADY low is the first ERROR cycle and is ignored.
            S_AHB_D: if (ahb.HREADY) begin
                state_d = S_RESP;
                if (ahb.HRESP) begin
                    rsp_d     = {RSP_ERR, 24'h0};
                    rsp_cnt_d = 3'd1;
                end else if (is_wr_q) begin
                    rsp_d     = {RSP_OK, 24'h0};
                    rsp_cnt_d = 3'd1;
                end else begin
                    rsp_d     = ahb.HRDATA;
                    rsp_cnt_d = 3'd4;
                end
            end
            S_RESP: if (rsp_cnt_q != 3'd0) begin
                if (tx_ready) begin
                    tx_start  = 1'b1;
                    rsp_d     = {rsp_q[23:0], 8'h00};
                    rsp_cnt_d = rsp_cnt_q - 1'b1;
                end
            end else if (!tx_busy) begin
                state_d = S_CMD;
            end
            default: state_d = S_CMD;
        endcase
`ifdef UART_DBG_MASTER_TIMEOUT_EN
        tmo_cnt_d = '0;
        if ((state_q == S_AHB_A || state_q == S_AHB_D) && !ahb.HREADY) begin
            if (tmo_cnt_q == TMO_LAST) begin
                htrans_d  = HTRANS_IDLE;
                rsp_d     = {RSP_TMO, 24'h0};
                rsp_cnt_d = 3'd1;
                state_d   = S_RESP;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end
`endif
        busy_d = (state_d != S_CMD);
    end

    // Registered state and bus outputs; reset aborts any frame or transfer silently.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= S_CMD;
            byte_cnt_q <= '0;
            is_wr_q    <= 1'b0;
            fld_q      <= '0;
            rsp_q      <= '0;
            rsp_cnt_q  <= '0;
            htrans_q   <= HTRANS_IDLE;
            haddr_q    <= '0;
            hwrite_q   <= 1'b0;
            hwdata_q   <= '0;
            busy_q     <= 1'b0;
`ifdef UART_DBG_MASTER_TIMEOUT_EN
            tmo_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            is_wr_q    <= is_wr_d;
            fld_q      <= fld_d;
            rsp_q      <= rsp_d;
            rsp_cnt_q  <= rsp_cnt_d;
            htrans_q   <= htrans_d;
            haddr_q    <= haddr_d;
            hwrite_q   <= hwrite_d;
            hwdata_q   <= hwdata_d;
            busy_q     <= busy_d;
`ifdef UART_DBG_MASTER_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_ahb_lite_uart_dbg_master.sv
// Directed bench: UART host driver, UART response monitor, small AHB slave model.
module tb_ahb_lite_uart_dbg_master;
    localparam int CLK_DIV     = 16;
    localparam int TIMEOUT_CYC = 16;

    logic HCLK = 1'b0;
    logic HRESET;
    logic UART_SRX = 1'b1;
    logic UART_STX, DBG_BUSY;

    ahb_lite_uart_dbg_master_if ahb();

    ahb_lite_uart_dbg_master #(.CLK_DIV(CLK_DIV), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .ahb      (ahb),
        .UART_SRX (UART_SRX),
        .UART_STX (UART_STX),
        .DBG_BUSY (DBG_BUSY)
    );

    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // ---------------- AHB slave model ----------------
    int          slv_wait  = 0;
    logic        slv_err   = 1'b0;
    logic        slv_stuck = 1'b0;
    logic [31:0] slv_rdata = '0;
    int          n_xfer    = 0;
    int          tr_held   = 0;
    logic [31:0] tr_addr   = '0;
    logic [31:0] tr_wdata  = '0;
    logic        tr_write  = 1'b0;
    logic        tr_dph_idle = 1'b0;

    initial begin
        ahb.HREADY = 1'b1;
        ahb.HRESP  = 1'b0;
        ahb.HRDATA = '0;
        forever begin
            @(negedge HCLK);
            if (ahb.HTRANS == 2'b10) begin
                n_xfer++;
                tr_addr  = ahb.HADDR;
                tr_write = ahb.HWRITE;
                tr_held  = 1;
                if (slv_stuck) begin
                    ahb.HREADY = 1'b0;
                    for (int i = 0; i < 4 * TIMEOUT_CYC; i++) begin
                        @(negedge HCLK);
                        if (ahb.HTRANS == 2'b10) tr_held++;
                        else break;
                    end
                    ahb.HREADY = 1'b1;
                end else begin
                    for (int w = 0; w < slv_wait; w++) begin
                        ahb.HREADY = 1'b0;
                        @(negedge HCLK);
                        if (ahb.HTRANS == 2'b10) tr_held++;
                    end
                    ahb.HREADY = 1'b1;
                    @(negedge HCLK);
                    tr_dph_idle = (ahb.HTRANS == 2'b00);
                    tr_wdata    = ahb.HWDATA;
                    if (slv_err) begin
                        ahb.HREADY = 1'b0;
                        ahb.HRESP  = 1'b1;
                        @(negedge HCLK);
                        ahb.HREADY = 1'b1;
                        @(negedge HCLK);
                        ahb.HRESP  = 1'b0;
                    end else begin
                        ahb.HRDATA = slv_rdata;
                        @(negedge HCLK);
                        ahb.HRDATA = '0;
                    end
                end
            end
        end
    end

    // ---------------- UART response monitor ----------------
    logic [7:0] rx_q[$];
    logic [7:0] mon_b;
    int         stop_errs    = 0;
    logic       busy_at_stop = 1'b0;

    initial begin
        forever begin
            @(negedge UART_STX);
            repeat (CLK_DIV / 2) @(negedge HCLK);
            if (UART_STX !== 1'b0) continue;
            for (int i = 0; i < 8; i++) begin
                repeat (CLK_DIV) @(negedge HCLK);
                mon_b[i] = UART_STX;
            end
            repeat (CLK_DIV) @(negedge HCLK);
            if (UART_STX !== 1'b1) stop_errs++;
            busy_at_stop = DBG_BUSY;
            rx_q.push_back(mon_b);
        end
    end

    // ---------------- host-side tasks ----------------
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge HCLK);
        UART_SRX = 1'b0;
        repeat (CLK_DIV) @(negedge HCLK);
        for (int i = 0; i < 8; i++) begin
            UART_SRX = b[i];
            repeat (CLK_DIV) @(negedge HCLK);
        end
        UART_SRX = stop_bit;
        repeat (CLK_DIV) @(negedge HCLK);
        UART_SRX = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24], 1'b1);
        send_byte(w[23:16], 1'b1);
        send_byte(w[15:8],  1'b1);
        send_byte(w[7:0],   1'b1);
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        logic [7:0] b;
        logic       ok;
        b  = 8'h00;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (rx_q.size() != 0) begin
                b  = rx_q.pop_front();
                ok = 1'b1;
                break;
            end
            @(negedge HCLK);
        end
        check(tag, {23'd0, ok, b}, {23'd0, 1'b1, exp});
    endtask

    task automatic wait_busy_low(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * CLK_DIV; i++) begin
            if (!DBG_BUSY) begin
                ok = 1'b1;
                break;
            end
            @(negedge HCLK);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int   x0;
        logic ok;
        HRESET = 1'b0;
        #2 HRESET = 1'b1;
        repeat (5) @(negedge HCLK);
        HRESET = 1'b0;
        @(negedge HCLK);

        check("rst_htrans", ahb.HTRANS, 32'h0);
        check("rst_haddr",  ahb.HADDR,  32'h0);
        check("rst_hwrite", ahb.HWRITE, 32'h0);
        check("rst_hwdata", ahb.HWDATA, 32'h0);
        check("rst_stx",    UART_STX,   32'h1);
        check("rst_busy",   DBG_BUSY,   32'h0);
        check("hsize",      ahb.HSIZE,  32'h2);
        check("hburst",     ahb.HBURST, 32'h0);
        check("hprot",      ahb.HPROT,  32'h3);
        check("hmastlock",  ahb.HMASTLOCK, 32'h0);

        // 1: zero-wait write
        x0 = n_xfer;
        send_byte(8'h57, 1'b1);
        @(negedge HCLK);
        check("t1_busy_after_cmd", DBG_BUSY, 32'h1);
        send_word(32'h0000_1004);
        send_word(32'hDEAD_BEEF);
        expect_byte("t1_rsp_K", 8'h4B);
        check("t1_xfers",   n_xfer - x0, 32'd1);
        check("t1_haddr",   tr_addr,     32'h0000_1004);
        check("t1_hwrite",  tr_write,    32'h1);
        check("t1_hwdata",  tr_wdata,    32'hDEAD_BEEF);
        check("t1_dph_idle", tr_dph_idle, 32'h1);

        // 2: read with 3 wait states held in address phase
        slv_wait  = 3;
        slv_rdata = 32'hCAFE_F00D;
        send_byte(8'h52, 1'b1);
        send_word(32'h0000_1004);
        expect_byte("t2_b0", 8'hCA);
        expect_byte("t2_b1", 8'hFE);
        expect_byte("t2_b2", 8'hF0);
        expect_byte("t2_b3", 8'h0D);
        check("t2_nonseq_held", tr_held, 32'd4);
        check("t2_haddr",  tr_addr,  32'h0000_1004);
        check("t2_hwrite", tr_write, 32'h0);
        slv_wait = 0;

        // 3: unknown command, then a normal read (address low bits dropped)
        x0 = n_xfer;
        send_byte(8'h11, 1'b1);
        expect_byte("t3_rsp_unk", 8'h3F);
        check("t3_no_xfer", n_xfer - x0, 32'd0);
        slv_rdata = 32'h1234_5678;
        send_byte(8'h52, 1'b1);
        send_word(32'h0000_000B);
        expect_byte("t3_b0", 8'h12);
        expect_byte("t3_b1", 8'h34);
        expect_byte("t3_b2", 8'h56);
        expect_byte("t3_b3", 8'h78);
        check("t3_haddr_aligned", tr_addr, 32'h0000_0008);

        // 4: two-cycle ERROR response on a read
        x0 = n_xfer;
        slv_err = 1'b1;
        send_byte(8'h52, 1'b1);
        send_word(32'h0000_0040);
        expect_byte("t4_rsp_E", 8'h45);
        check("t4_busy_at_stop", busy_at_stop, 32'h1);
        wait_busy_low(ok);
        check("t4_busy_falls", ok, 32'h1);
        repeat (12 * CLK_DIV) @(negedge HCLK);
        check("t4_single_byte", rx_q.size(), 32'd0);
        check("t4_htrans_idle", ahb.HTRANS, 32'h0);
        check("t4_xfers", n_xfer - x0, 32'd1);
        slv_err = 1'b0;

        // 5: framing error inside the address field, then a good write
        x0 = n_xfer;
        send_byte(8'h57, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h12, 1'b0);
        repeat (4 * CLK_DIV) @(negedge HCLK);
        check("t5_busy_cleared", DBG_BUSY, 32'h0);
        check("t5_no_rsp", rx_q.size(), 32'd0);
        check("t5_no_xfer", n_xfer - x0, 32'd0);
        send_byte(8'h57, 1'b1);
        send_word(32'h0000_2000);
        send_word(32'h1122_3344);
        expect_byte("t5_rsp_K", 8'h4B);
        check("t5_xfers", n_xfer - x0, 32'd1);
        check("t5_haddr", tr_addr, 32'h0000_2000);
        check("t5_hwdata", tr_wdata, 32'h1122_3344);

`ifdef UART_DBG_MASTER_TIMEOUT_EN
        // 6a: HREADY stuck low -> abort after TIMEOUT_CYC cycles
        slv_stuck = 1'b1;
        send_byte(8'h52, 1'b1);
        send_word(32'h0000_0080);
        expect_byte("t6_rsp_T", 8'h54);
        check("t6_nonseq_cycles", tr_held, 32'd16);
        check("t6_htrans_idle", ahb.HTRANS, 32'h0);
        slv_stuck = 1'b0;
`endif

        check("stop_bits", stop_errs, 32'd0);

        // 6b: reset during a response byte
        send_byte(8'h11, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (UART_STX == 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge HCLK);
        end
        check("t6_tx_started", ok, 32'h1);
        repeat (3 * CLK_DIV) @(negedge HCLK);
        HRESET = 1'b1;
        #1;
        check("t6_rst_stx",    UART_STX,   32'h1);
        check("t6_rst_busy",   DBG_BUSY,   32'h0);
        check("t6_rst_htrans", ahb.HTRANS, 32'h0);
        @(negedge HCLK);
        HRESET = 1'b0;
        repeat (12 * CLK_DIV) @(negedge HCLK);
        rx_q.delete();
        send_byte(8'h00, 1'b1);
        expect_byte("t6_after_rst_unk", 8'h3F);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
